// File: rtl/arc4_pkg.sv
// Shared definitions for the ARC4 key-scheduling and pseudo-random generation stages.
// Memory geometry, the length-prefix location and the PRGA state encoding live here.
package arc4_pkg;

   localparam int MEM_DEPTH        = 256;
   localparam int DATA_W           = 8;
   localparam int ADDR_W           = $clog2(MEM_DEPTH);
   localparam int MAX_CYC_PER_BYTE = 12;

   localparam logic [ADDR_W-1:0] LEN_ADDR = '0;

   typedef enum logic [3:0] {
      IDLE,
      RD_LEN,
      WR_LEN,
      RD_SI,
      RD_SJ,
      WR_SI,
      WR_SJ,
      RD_PAD,
      WR_PT,
      DONE
   } prga_state_t;

endpackage

// File: rtl/arc4_prga.sv
// ARC4 pseudo-random generation stage: swaps through the scheduled S array and
// XORs the keystream into a length-prefixed ciphertext, producing length-prefixed plaintext.
module arc4_prga
   import arc4_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic              rdy,
   output logic [ADDR_W-1:0] s_addr,
   input  logic [DATA_W-1:0] s_rddata,
   output logic [DATA_W-1:0] s_wrdata,
   output logic              s_wren,
   output logic [ADDR_W-1:0] ct_addr,
   input  logic [DATA_W-1:0] ct_rddata,
   output logic [ADDR_W-1:0] pt_addr,
   output logic [DATA_W-1:0] pt_wrdata,
   output logic              pt_wren
);

   localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   prga_state_t       state_reg, state_next;
   logic [WAIT_W-1:0] wait_reg;
   logic [ADDR_W-1:0] i_reg, j_reg, k_reg;
   logic [DATA_W-1:0] len_reg, si_reg, sj_reg;
   logic              lat_done;
   logic              first_cyc;
   logic              in_read;

   // Read states hold their address for MEM_LAT cycles; the data is valid in
   // the first cycle of the state that follows.
   assign lat_done  = (wait_reg == WAIT_W'(MEM_LAT - 1));
   assign first_cyc = (wait_reg == '0);
   assign in_read   = (state_reg == RD_LEN) || (state_reg == RD_SI) ||
                      (state_reg == RD_SJ)  || (state_reg == RD_PAD);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         wait_reg  <= '0;
         i_reg     <= '0;
         j_reg     <= '0;
         k_reg     <= '0;
         len_reg   <= '0;
         si_reg    <= '0;
         sj_reg    <= '0;
      end else begin
         state_reg <= state_next;
         if (in_read && !lat_done)
            wait_reg <= wait_reg + 1'b1;
         else
            wait_reg <= '0;

         case (state_reg)
            WR_LEN: begin
               len_reg <= ct_rddata;
               i_reg   <= '0;
               j_reg   <= '0;
               k_reg   <= '0;
            end
            RD_SI: begin
               if (lat_done) begin
                  i_reg <= i_reg + 1'b1;
                  k_reg <= k_reg + 1'b1;
               end
            end
            RD_SJ: begin
               // S[i] arrives in the first cycle here; j is advanced immediately
               // so the held address below stays constant for the rest of the wait.
               if (first_cyc) begin
                  si_reg <= s_rddata;
                  j_reg  <= j_reg + s_rddata;
               end
            end
            WR_SI: sj_reg <= s_rddata;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state_reg;
      rdy        = 1'b0;
      s_addr     = '0;
      s_wrdata   = '0;
      s_wren     = 1'b0;
      ct_addr    = '0;
      pt_addr    = '0;
      pt_wrdata  = '0;
      pt_wren    = 1'b0;

      case (state_reg)
         IDLE: begin
            rdy = 1'b1;
            if (en)
               state_next = RD_LEN;
         end
         RD_LEN: begin
            ct_addr = LEN_ADDR;
            if (lat_done)
               state_next = WR_LEN;
         end
         WR_LEN: begin
            pt_addr   = LEN_ADDR;
            pt_wrdata = ct_rddata;
            pt_wren   = 1'b1;
            state_next = (ct_rddata == '0) ? DONE : RD_SI;
         end
         RD_SI: begin
            s_addr = i_reg + 1'b1;
            if (lat_done)
               state_next = RD_SJ;
         end
         RD_SJ: begin
            s_addr = first_cyc ? (j_reg + s_rddata) : j_reg;
            if (lat_done)
               state_next = WR_SI;
         end
         WR_SI: begin
            s_addr   = i_reg;
            s_wrdata = s_rddata;
            s_wren   = 1'b1;
            state_next = WR_SJ;
         end
         WR_SJ: begin
            s_addr   = j_reg;
            s_wrdata = si_reg;
            s_wren   = 1'b1;
            state_next = RD_PAD;
         end
         RD_PAD: begin
            // Issued after both swap writes, so the pad sees the swapped S.
            s_addr  = si_reg + sj_reg;
            ct_addr = k_reg;
            if (lat_done)
               state_next = WR_PT;
         end
         WR_PT: begin
            pt_addr   = k_reg;
            pt_wrdata = s_rddata ^ ct_rddata;
            pt_wren   = 1'b1;
            state_next = (k_reg == len_reg) ? DONE : RD_SI;
         end
         DONE: begin
            rdy        = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_arc4_prga.sv
// Bench for arc4_prga: behavioural RAMs around the DUT and a plain-arithmetic ARC4
// reference (KSA + PRGA loops) producing the expected plaintext and final S array.
module tb_arc4_prga;
   import arc4_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       rdy;
   logic [7:0] s_addr, s_rddata, s_wrdata;
   logic       s_wren;
   logic [7:0] ct_addr, ct_rddata;
   logic [7:0] pt_addr, pt_wrdata;
   logic       pt_wren;

   logic [7:0] s_mem  [256];
   logic [7:0] ct_mem [256];
   logic [7:0] pt_mem [256];
   logic [7:0] ref_s  [256];
   logic [7:0] ref_pt [256];
   logic [7:0] ct_ref [256];

   int total = 0;
   int bad   = 0;
   int s_wr_cnt = 0, pt_wr_cnt = 0, idle_wr_cnt = 0, rdy_fall_cnt = 0;
   logic rdy_q = 1'b1;

   always #5 clk = ~clk;

   arc4_prga #(.MEM_LAT(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .rdy       (rdy),
      .s_addr    (s_addr),
      .s_rddata  (s_rddata),
      .s_wrdata  (s_wrdata),
      .s_wren    (s_wren),
      .ct_addr   (ct_addr),
      .ct_rddata (ct_rddata),
      .pt_addr   (pt_addr),
      .pt_wrdata (pt_wrdata),
      .pt_wren   (pt_wren)
   );

   // Single-port RAMs with registered address: one cycle read latency.
   always @(posedge clk) begin
      s_rddata  <= s_mem[s_addr];
      ct_rddata <= ct_mem[ct_addr];
      if (s_wren)  s_mem[s_addr]   <= s_wrdata;
      if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
   end

   always @(negedge clk) begin
      if (s_wren)  s_wr_cnt++;
      if (pt_wren) pt_wr_cnt++;
      if (rdy && (s_wren || pt_wren)) idle_wr_cnt++;
      if (rdy_q && !rdy) rdy_fall_cnt++;
      rdy_q = rdy;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ksa();
      logic [7:0] key [3];
      logic [7:0] j, t;
      key = '{8'h00, 8'h03, 8'h3C};
      j = 8'h00;
      for (int x = 0; x < 256; x++) ref_s[x] = 8'(x);
      for (int x = 0; x < 256; x++) begin
         j = j + ref_s[x] + key[x % 3];
         t = ref_s[x]; ref_s[x] = ref_s[j]; ref_s[j] = t;
      end
   endtask

   task automatic ref_run();
      logic [7:0] i, j, si, sj, idx;
      int len;
      len = int'(ct_ref[0]);
      ref_pt[0] = ct_ref[0];
      i = 8'h00; j = 8'h00;
      for (int k = 1; k <= len; k++) begin
         i = i + 8'h01;
         si = ref_s[i];
         j = j + si;
         sj = ref_s[j];
         ref_s[i] = sj;
         ref_s[j] = si;
         idx = si + sj;
         ref_pt[k] = ref_s[idx] ^ ct_ref[k];
      end
   endtask

   task automatic load_mems();
      for (int x = 0; x < 256; x++) begin
         s_mem[x]  <= ref_s[x];
         ct_mem[x] <= ct_ref[x];
         pt_mem[x] <= 8'hAA;
      end
      @(negedge clk);
   endtask

   task automatic set_ct(input int len, input int fill_mode);
      ct_ref[0] = 8'(len);
      for (int x = 1; x < 256; x++)
         ct_ref[x] = (fill_mode == 0) ? 8'h00 : (fill_mode == 1) ? 8'hFF : 8'($urandom_range(0, 255));
   endtask

   task automatic start_run(input string tag);
      int n;
      n = 0;
      while (!rdy && n < 100) begin @(negedge clk); n++; end
      en = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (rdy && n < 8);
      en = 1'b0;
      check({tag, "_started"}, 32'(rdy), 32'd0);
   endtask

   task automatic wait_done(input string tag, output int cyc);
      cyc = 1;
      while (!rdy && cyc < 5000) begin @(negedge clk); cyc++; end
      check({tag, "_done"}, 32'(rdy), 32'd1);
   endtask

   task automatic check_results(input string tag);
      int len;
      len = int'(ct_ref[0]);
      for (int k = 0; k <= len; k++)
         check($sformatf("%s_pt[%0d]", tag, k), 32'(pt_mem[k]), 32'(ref_pt[k]));
      if (len < 255)
         check($sformatf("%s_pt_beyond", tag), 32'(pt_mem[len+1]), 32'h000000AA);
      for (int x = 0; x < 256; x++)
         check($sformatf("%s_S[%0d]", tag, x), 32'(s_mem[x]), 32'(ref_s[x]));
   endtask

   initial begin
      int cyc, s0, p0, f0;
      rst = 1'b1;
      en  = 1'b0;
      for (int x = 0; x < 256; x++) begin ref_s[x] = 8'(x); ct_ref[x] = 8'h00; end
      load_mems();
      repeat (3) @(negedge clk);
      check("rst_rdy", 32'(rdy), 32'd1);
      check("rst_s_wren", 32'(s_wren), 32'd0);
      check("rst_pt_wren", 32'(pt_wren), 32'd0);
      check("rst_addrs", {s_addr, ct_addr, pt_addr, 8'h00}, 32'd0);
      check("rst_wrdata", {16'h0000, s_wrdata, pt_wrdata}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Identity S, zero ciphertext: plaintext is the raw keystream.
      for (int x = 0; x < 256; x++) ref_s[x] = 8'(x);
      set_ct(3, 0);
      load_mems();
      start_run("A");
      wait_done("A", cyc);
      ref_run();
      check_results("A");
      check("A_pt_const", {pt_mem[0], pt_mem[1], pt_mem[2], pt_mem[3]}, 32'h03020507);
      check("A_swaps_const", {8'h00, s_mem[2], s_mem[3], s_mem[5]}, 32'h00030502);

      // Identity S, all-ones ciphertext, with a latency bound.
      for (int x = 0; x < 256; x++) ref_s[x] = 8'(x);
      set_ct(3, 1);
      load_mems();
      start_run("B");
      wait_done("B", cyc);
      ref_run();
      check_results("B");
      check("B_pt_const", {pt_mem[0], pt_mem[1], pt_mem[2], pt_mem[3]}, 32'h03FDFAF8);
      check("B_cycles_ok", 32'(cyc + 1 <= 3 * MAX_CYC_PER_BYTE + 4), 32'd1);

      // Empty message.
      ksa();
      set_ct(0, 2);
      load_mems();
      s0 = s_wr_cnt; p0 = pt_wr_cnt;
      start_run("C");
      wait_done("C", cyc);
      ref_run();
      check_results("C");
      check("C_pt_writes", 32'(pt_wr_cnt - p0), 32'd1);
      check("C_s_writes", 32'(s_wr_cnt - s0), 32'd0);
      check("C_cycles_ok", 32'(cyc + 1 <= 4), 32'd1);

      // Full-length message over a KSA-scheduled S.
      ksa();
      set_ct(255, 2);
      load_mems();
      p0 = pt_wr_cnt;
      start_run("G");
      wait_done("G", cyc);
      ref_run();
      check_results("G");
      check("G_pt0", 32'(pt_mem[0]), 32'h000000FF);
      check("G_pt_writes", 32'(pt_wr_cnt - p0), 32'd256);
      check("G_cycles_ok", 32'(cyc + 1 <= 255 * MAX_CYC_PER_BYTE + 4), 32'd1);

      // Abort mid-run, then a clean run from restored memories.
      ksa();
      set_ct(40, 2);
      load_mems();
      start_run("R");
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("R_rdy", 32'(rdy), 32'd1);
      check("R_wren", {30'd0, s_wren, pt_wren}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      load_mems();
      start_run("R2");
      wait_done("R2", cyc);
      ref_run();
      check_results("R2");

      // en held high: exactly two back-to-back runs, second continues from evolved S.
      ksa();
      set_ct(10, 2);
      load_mems();
      f0 = rdy_fall_cnt; p0 = pt_wr_cnt;
      en = 1'b1;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (rdy && cyc < 8);
      wait_done("H1", cyc);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (rdy && cyc < 8);
      en = 1'b0;
      check("H2_started", 32'(rdy), 32'd0);
      wait_done("H2", cyc);
      ref_run();
      ref_run();
      check_results("H");
      check("H_run_count", 32'(rdy_fall_cnt - f0), 32'd2);
      check("H_pt_writes", 32'(pt_wr_cnt - p0), 32'd22);

      check("no_wren_while_rdy", 32'(idle_wr_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
